// File: rtl/fm_pkg.sv
// Purpose: shared types and constants for the FM frequency meter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fm_pkg;

  // Frequency-word width shared with the DDS generator.
  localparam int PW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    DIV  = 2'd2
  } meter_state_e;

  typedef logic signed [PW_DEF-1:0] freq_word_t;

endpackage

// File: rtl/fm_freq_meter_div.sv
// Purpose: sequential restoring unsigned divider, one quotient bit per enabled cycle.
// Latency: NW enabled cycles after start; done/quo are valid combinationally on the last one.
// Backpressure: none; en low freezes the iteration, start must only be pulsed when idle.
// Ports: clk, rst (async active-low), en, start, num/den operands in, done strobe, quo result.
module seq_udiv #(
  parameter int NW = 37,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          done,
  output logic [NW-1:0] quo
);

  localparam int SW = $clog2(NW);

  logic          active;
  logic [SW-1:0] step;
  logic [NW-1:0] num_sh;
  logic [NW-1:0] q;
  logic [DW-1:0] den_q;
  logic [DW-1:0] rem;

  logic [DW:0]   trial;
  logic [DW:0]   diff;
  logic          ge;
  logic [DW-1:0] rem_nxt;

  // rem < den always, so trial < 2*den and the restored remainder fits DW bits.
  always_comb begin
    trial   = {rem, num_sh[NW-1]};
    diff    = trial - {1'b0, den_q};
    ge      = (trial >= {1'b0, den_q});
    rem_nxt = ge ? diff[DW-1:0] : trial[DW-1:0];
  end

  assign quo  = {q[NW-2:0], ge};
  assign done = active & en & (step == SW'(NW-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= 1'b0;
      step   <= '0;
      num_sh <= '0;
      q      <= '0;
      den_q  <= '0;
      rem    <= '0;
    end else if (start) begin
      active <= 1'b1;
      step   <= '0;
      num_sh <= num;
      q      <= '0;
      den_q  <= den;
      rem    <= '0;
    end else if (active && en) begin
      num_sh <= num_sh << 1;
      q      <= quo;
      rem    <= rem_nxt;
      step   <= step + 1'b1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/fm_freq_meter.sv
// Purpose: measures the frequency of a signed sinusoid over 2^LNP periods, output as a DDS tuning word.
// Latency: gate of 2^LNP periods, then PW+LNP+1 enabled cycles of division before freq_vld.
// Backpressure: none; en low freezes everything, freq_vld is a single-cycle pulse regardless of en.
// Ports: clk, rst (async active-low), en, din (signed sample) in; freq, freq_vld, no_sig, busy out.
module fm_freq_meter
  import fm_pkg::*;
#(
  parameter int PW   = PW_DEF,
  parameter int DW   = 10,
  parameter int LNP  = 4,
  parameter int CW   = 24,
  parameter int HYST = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [DW-1:0] din,
  output logic signed [PW-1:0] freq,
  output logic                 freq_vld,
  output logic                 no_sig,
  output logic                 busy
);

  localparam int NW = PW + LNP + 1;
  localparam logic [CW-1:0]        CNT_MAX  = '1;
  localparam logic [LNP-1:0]       ECNT_END = '1;
  localparam logic signed [DW-1:0] THR_HI   = DW'(HYST);
  localparam logic signed [DW-1:0] THR_LO   = DW'(-HYST);
  // Dividend 2^(PW+LNP): NP periods scaled to the DDS word.
  localparam logic [NW-1:0]        DIVIDEND = {1'b1, {(NW-1){1'b0}}};
  localparam logic [PW-1:0]        FREQ_SAT = {1'b0, {(PW-1){1'b1}}};

  meter_state_e   state;
  logic [CW-1:0]  cnt;
  logic [LNP-1:0] ecnt;
  logic           pol;
  logic           edge_stb;

  logic           above;
  logic           below;
  logic           div_start;
  logic           div_done;
  logic [NW-1:0]  quo;
  logic [PW-1:0]  quo_sat;

  assign above = (din > THR_HI);
  assign below = (din < THR_LO);

  // Hysteretic polarity tracker; the edge strobe holds through disabled
  // cycles so the FSM sees it on the next enabled cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pol      <= 1'b0;
      edge_stb <= 1'b0;
    end else if (en) begin
      edge_stb <= above & ~pol;
      if (above)      pol <= 1'b1;
      else if (below) pol <= 1'b0;
    end
  end

  // Closing edge of the gate; cnt+1 is then the enabled-cycle span of NP periods.
  assign div_start = en & (state == MEAS) & edge_stb & (ecnt == ECNT_END) & (cnt != CNT_MAX);

  seq_udiv #(
    .NW (NW),
    .DW (CW)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (div_start),
    .num   (DIVIDEND),
    .den   (cnt + 1'b1),
    .done  (div_done),
    .quo   (quo)
  );

  // Anything at or above 2^(PW-1) does not fit the signed word.
  assign quo_sat = (|quo[NW-1:PW-1]) ? FREQ_SAT : quo[PW-1:0];
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ecnt     <= '0;
      freq     <= '0;
      freq_vld <= 1'b0;
      no_sig   <= 1'b0;
    end else begin
      freq_vld <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (edge_stb) begin
              state <= MEAS;
              cnt   <= '0;
              ecnt  <= '0;
            end else if (cnt == CNT_MAX) begin
              cnt      <= '0;
              freq     <= '0;
              freq_vld <= 1'b1;
              no_sig   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          MEAS: begin
            if (cnt == CNT_MAX) begin
              state    <= IDLE;
              cnt      <= '0;
              freq     <= '0;
              freq_vld <= 1'b1;
              no_sig   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
              if (edge_stb) begin
                if (ecnt == ECNT_END) state <= DIV;
                else                  ecnt  <= ecnt + 1'b1;
              end
            end
          end
          DIV: begin
            if (div_done) begin
              state    <= IDLE;
              cnt      <= '0;
              freq     <= $signed(quo_sat);
              freq_vld <= 1'b1;
              no_sig   <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fm_freq_meter.sv
// Purpose: self-checking bench for fm_freq_meter (default build plus a CW=12 build for timeout).
// Latency: n/a.
// Backpressure: n/a.
module tb_fm_freq_meter;

  localparam int DW = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 en  = 1'b1;
  logic signed [DW-1:0] din = '0;

  logic signed [31:0] freq_a, freq_b;
  logic               vld_a, vld_b, nosig_a, nosig_b, busy_a, busy_b;

  fm_freq_meter dut_a (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .freq(freq_a), .freq_vld(vld_a), .no_sig(nosig_a), .busy(busy_a)
  );

  fm_freq_meter #(.CW(12)) dut_b (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .freq(freq_b), .freq_vld(vld_b), .no_sig(nosig_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus state
  int period = 64;
  int ph     = 0;
  bit sq     = 0;
  bit tog    = 0;
  bit dith   = 0;
  bit zero   = 1;

  typedef struct {
    string       name;
    int          period;
    bit          sq;
    bit          tog;
    bit          dith;
    logic [31:0] exp_freq;
  } vec_t;

  vec_t vecs[5];

  function automatic int sine_at(input int p, input int per);
    real a;
    a = 511.0 * $sin(2.0 * 3.14159265358979 * real'(p) / real'(per));
    return $rtoi($floor(a + 0.5));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: wait the edge, then present the next sample.
  task automatic cycle();
    int d;
    @(posedge clk);
    #1;
    en = tog ? ~en : 1'b1;
    if (en) begin
      if (zero)    d = 0;
      else if (sq) d = (ph % 2 == 0) ? 511 : -511;
      else         d = sine_at(ph % period, period);
      if (dith) d = d + int'($urandom_range(20)) - 10;
      if (d > 511)  d = 511;
      if (d < -512) d = -512;
      din = DW'(d);
      ph++;
    end
  endtask

  task automatic wait_vld(input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (vld_a) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic wait_busy(input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (busy_a) begin
        got = 1;
        break;
      end
    end
  endtask

  initial begin
    bit got;
    int k;
    int bc;

    vecs[0] = '{"sine64",       64,  0, 0, 0, 32'd67108864};
    vecs[1] = '{"sine100",      100, 0, 0, 0, 32'd42949672};
    vecs[2] = '{"square2_sat",  2,   1, 0, 0, 32'h7FFF_FFFF};
    vecs[3] = '{"sine64_dith",  64,  0, 1, 1, 32'd67108864};
    vecs[4] = '{"sine100_entog",100, 0, 1, 0, 32'd42949672};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_freq",   $unsigned(freq_a), 0);
    chk("rst_vld",    vld_a, 0);
    chk("rst_no_sig", nosig_a, 0);
    chk("rst_busy",   busy_a, 0);
    rst = 1'b1;

    // No signal: CW=12 build times out after 4096 enabled cycles
    k = 0;
    got = 0;
    for (int i = 0; i < 5000; i++) begin
      cycle();
      k++;
      if (vld_b) begin
        got = 1;
        break;
      end
    end
    chk("timeout_seen",   got, 1);
    chk("timeout_cycles", k, 4096);
    chk("timeout_freq",   $unsigned(freq_b), 0);
    chk("timeout_no_sig", nosig_b, 1);
    chk("default_no_timeout", nosig_a, 0);

    // Sine period 64 from a clean zero crossing: exact gate+division timing
    zero = 0; period = 64; ph = 0;
    wait_busy(200, got);
    chk("lat_busy_seen", got, 1);
    bc = 1;
    got = 0;
    for (int i = 0; i < 2000; i++) begin
      cycle();
      if (vld_a) begin
        got = 1;
        break;
      end
      if (busy_a) bc++;
    end
    chk("lat_vld_seen",   got, 1);
    chk("lat_busy_cycles", bc, 1061);
    chk("lat_freq",       $unsigned(freq_a), 32'd67108864);
    chk("lat_freq_b",     $unsigned(freq_b), 32'd67108864);
    chk("lat_vld_b",      vld_b, 1);
    chk("lat_no_sig_b",   nosig_b, 0);
    cycle();
    chk("lat_vld_pulse",  vld_a, 0);

    // Reset pulse in the middle of division
    wait_busy(200, got);
    chk("rstdiv_busy_seen", got, 1);
    repeat (1030) cycle();
    chk("rstdiv_in_div", busy_a, 1);
    rst = 1'b0;
    #1;
    chk("rstdiv_freq",   $unsigned(freq_a), 0);
    chk("rstdiv_vld",    vld_a, 0);
    chk("rstdiv_busy",   busy_a, 0);
    chk("rstdiv_no_sig", nosig_a, 0);
    cycle();
    rst = 1'b1;
    wait_vld(3000, got);
    chk("rstdiv_gate1_seen", got, 1);
    wait_vld(3000, got);
    chk("rstdiv_gate2_seen", got, 1);
    chk("rstdiv_gate2_freq", $unsigned(freq_a), 32'd67108864);

    // Table of steady-state vectors: first gate after a change is discarded
    for (int v = 0; v < 5; v++) begin
      period = vecs[v].period;
      sq     = vecs[v].sq;
      tog    = vecs[v].tog;
      dith   = vecs[v].dith;
      ph     = 0;
      wait_vld(10000, got);
      chk({vecs[v].name, "_gate1_seen"}, got, 1);
      wait_vld(10000, got);
      chk({vecs[v].name, "_gate2_seen"}, got, 1);
      chk({vecs[v].name, "_freq"},   $unsigned(freq_a), vecs[v].exp_freq);
      chk({vecs[v].name, "_no_sig"}, nosig_a, 0);
      cycle();
      chk({vecs[v].name, "_vld_pulse"}, vld_a, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
